prog_clock_divider: RTL and testbench

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

---
 rtl/prog_clock_divider.sv | 103 ++++++++++
 tb/tb_prog_clock_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider. Each channel runs a 0..act-1 period
// counter; divisor changes are staged in pend and adopted only at period boundaries.
module prog_clock_divider #(
  parameter int unsigned CH      = 2,
  parameter int unsigned W       = 28,
  parameter int unsigned DEF_DIV = 50000000,
  parameter int unsigned MIN_DIV = 2,
  parameter int unsigned MAX_DIV = (1 << W) - 1,
  parameter int unsigned STEP    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   en,
  input  logic [CH*W-1:0] div_in,
  input  logic [CH-1:0]   load,
  input  logic [CH-1:0]   inc,
  input  logic [CH-1:0]   dec,
  output logic [CH-1:0]   clk_out,
  output logic [CH-1:0]   tick,
  output logic [CH*W-1:0] div_cur
);

  localparam logic [W-1:0] MIN_W  = W'(MIN_DIV);
  localparam logic [W-1:0] MAX_W  = W'(MAX_DIV);
  localparam logic [W-1:0] DEF_W  = W'(DEF_DIV);
  localparam logic [W:0]   MIN_X  = (W+1)'(MIN_DIV);
  localparam logic [W:0]   MAX_X  = (W+1)'(MAX_DIV);
  localparam logic [W:0]   STEP_X = (W+1)'(STEP);

  if (!(MIN_DIV >= 2 && MIN_DIV <= DEF_DIV && DEF_DIV <= MAX_DIV &&
        64'(MAX_DIV) < (64'(1) << W) && STEP >= 1 && CH >= 1)) begin : g_param_err
    $error("prog_clock_divider: illegal parameters (need 2 <= MIN_DIV <= DEF_DIV <= MAX_DIV < 2**W, STEP >= 1)");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] pend;
    logic [W-1:0] act;
    logic [W-1:0] cnt;
    logic [W-1:0] pend_nxt;
    logic [W-1:0] div_ch;
    logic [W:0]   pend_x;
    logic [W:0]   inc_x;
    logic [W:0]   dec_x;
    logic         wrap;
    logic         clk_q;
    logic         tick_q;

    assign div_ch = div_in[i*W +: W];
    // One extra bit so saturation is decided before any W-bit wrap-around.
    assign pend_x = {1'b0, pend};
    assign inc_x  = pend_x + STEP_X;
    assign dec_x  = pend_x - STEP_X;
    assign wrap   = (cnt == act - 1'b1);

    always_comb begin
      pend_nxt = pend;
      if (load[i]) begin
        if (div_ch < MIN_W)
          pend_nxt = MIN_W;
        else if (div_ch > MAX_W)
          pend_nxt = MAX_W;
        else
          pend_nxt = div_ch;
      end else if (inc[i] && !dec[i]) begin
        if (inc_x > MAX_X)
          pend_nxt = MAX_W;
        else
          pend_nxt = inc_x[W-1:0];
      end else if (dec[i] && !inc[i]) begin
        if (pend_x < STEP_X || dec_x < MIN_X)
          pend_nxt = MIN_W;
        else
          pend_nxt = dec_x[W-1:0];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pend   <= DEF_W;
        act    <= DEF_W;
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        pend   <= pend_nxt;
        clk_q  <= en[i] && (cnt < (act >> 1));
        tick_q <= en[i] && (cnt == '0);
        // A divisor written on the wrap cycle is adopted on that same edge.
        if (!en[i] || wrap) begin
          cnt <= '0;
          act <= pend_nxt;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign clk_out[i]         = clk_q;
    assign tick[i]            = tick_q;
    assign div_cur[i*W +: W]  = act;
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: period-level reference model checked every
// cycle, plus literal waveform/divisor expectations for the key scenarios.
module tb_prog_clock_divider;

  localparam int CH = 2;
  localparam int W = 8;
  localparam int DEF = 4;
  localparam int MIN = 2;
  localparam int MAX = 250;
  localparam int STEP = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   en;
  logic [CH*W-1:0] div_in;
  logic [CH-1:0]   load;
  logic [CH-1:0]   inc;
  logic [CH-1:0]   dec;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   tick;
  logic [CH*W-1:0] div_cur;

  prog_clock_divider #(
    .CH(CH), .W(W), .DEF_DIV(DEF), .MIN_DIV(MIN), .MAX_DIV(MAX), .STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_in(div_in), .load(load),
    .inc(inc), .dec(dec), .clk_out(clk_out), .tick(tick), .div_cur(div_cur)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] cap0;

  // Model: pending divisor, position within the current period (-1 = idle), period length.
  int m_pend [CH];
  int m_pos  [CH];
  int m_len  [CH];
  bit e_clk  [CH];
  bit e_tick [CH];
  int e_div  [CH];

  function automatic int next_pend(int p, bit ld, bit up, bit dn, int d);
    if (ld) return (d < MIN) ? MIN : (d > MAX) ? MAX : d;
    if (up && !dn) return (p + STEP > MAX) ? MAX : p + STEP;
    if (dn && !up) return (p - STEP < MIN) ? MIN : p - STEP;
    return p;
  endfunction

  task automatic model_update();
    for (int c = 0; c < CH; c++) begin
      if (!rst_n) begin
        m_pend[c] = DEF; m_pos[c] = -1; m_len[c] = DEF;
        e_clk[c] = 1'b0; e_tick[c] = 1'b0; e_div[c] = DEF;
      end else begin
        int np;
        np = next_pend(m_pend[c], load[c], inc[c], dec[c], int'(div_in[c*W +: W]));
        if (en[c]) begin
          if (m_pos[c] < 0 || m_pos[c] == m_len[c] - 1) begin
            m_pos[c] = 0;
            m_len[c] = m_pend[c];
          end else begin
            m_pos[c]++;
          end
          e_clk[c]  = (m_pos[c] < m_len[c] / 2);
          e_tick[c] = (m_pos[c] == 0);
          e_div[c]  = (m_pos[c] == m_len[c] - 1) ? np : m_len[c];
        end else begin
          m_pos[c] = -1;
          e_clk[c] = 1'b0; e_tick[c] = 1'b0; e_div[c] = np;
        end
        m_pend[c] = np;
      end
    end
  endtask

  task automatic chk(string name, longint actual, longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("clk_out[%0d]", c), clk_out[c], e_clk[c]);
      chk($sformatf("tick[%0d]", c), tick[c], e_tick[c]);
      chk($sformatf("div_cur[%0d]", c), div_cur[c*W +: W], e_div[c]);
    end
    cap0 = {cap0[30:0], clk_out[0]};
  endtask

  initial begin
    rst_n = 1'b0; en = '0; div_in = '0; load = '0; inc = '0; dec = '0; cap0 = '0;

    // Reset state
    repeat (3) cycle();
    chk("reset_div_cur", div_cur, {8'd4, 8'd4});
    chk("reset_clk_out", clk_out, 0);
    chk("reset_tick", tick, 0);

    // Divide by 4 on channel 0
    rst_n = 1'b1; en = 2'b01; cap0 = '0;
    repeat (8) cycle();
    chk("div4_pattern", cap0[7:0], 8'b11001100);

    // Load 6 mid-period: current 4-cycle period finishes first
    cap0 = '0;
    cycle();
    load[0] = 1'b1; div_in[7:0] = 8'd6;
    cycle();
    load = '0;
    repeat (8) cycle();
    chk("load6_pattern", cap0[9:0], 10'b1100111000);

    // Load 5 at a period start: the 6-period in flight completes, then 2 high / 3 low
    cap0 = '0;
    load[0] = 1'b1; div_in[7:0] = 8'd5;
    cycle();
    load = '0;
    repeat (11) cycle();
    chk("load5_pattern", cap0[11:0], 12'b111000110001);

    // Load 0 clamps to 2: output toggles every cycle
    cap0 = '0;
    load[0] = 1'b1; div_in[7:0] = 8'd0;
    cycle();
    load = '0;
    repeat (7) cycle();
    chk("load0_pattern", cap0[7:0], 8'b10001010);

    // Load 255 clamps to 250, visible once disabled
    load[0] = 1'b1; div_in[7:0] = 8'd255;
    cycle();
    load = '0; en = '0;
    repeat (2) cycle();
    chk("load255_clamp", div_cur[7:0], 250);

    // Pending-divisor arithmetic on idle channel 1
    load[1] = 1'b1; div_in[15:8] = 8'd4;
    cycle();
    load = '0; dec[1] = 1'b1;
    repeat (5) cycle();
    dec = '0;
    chk("dec_saturate", div_cur[15:8], 2);
    inc[1] = 1'b1; dec[1] = 1'b1;
    cycle();
    inc = '0; dec = '0;
    chk("inc_dec_hold", div_cur[15:8], 2);
    load[1] = 1'b1; inc[1] = 1'b1; div_in[15:8] = 8'd9;
    cycle();
    load = '0; inc = '0;
    chk("load_over_inc", div_cur[15:8], 9);
    load[1] = 1'b1; div_in[15:8] = 8'd249;
    cycle();
    load = '0; inc[1] = 1'b1;
    repeat (2) cycle();
    inc = '0;
    chk("inc_saturate", div_cur[15:8], 250);
    load[1] = 1'b1; div_in[15:8] = 8'd3;
    load[0] = 1'b1; div_in[7:0] = 8'd4;
    cycle();
    load = '0;

    // Enable both, drop ch0 mid-period, load 8, re-enable
    en = 2'b11;
    repeat (2) cycle();
    en[0] = 1'b0; load[0] = 1'b1; div_in[7:0] = 8'd8;
    cycle();
    load = '0;
    repeat (2) cycle();
    chk("disabled_clk_out0", clk_out[0], 0);
    chk("disabled_tick0", tick[0], 0);
    chk("disabled_div_cur0", div_cur[7:0], 8);
    en[0] = 1'b1; cap0 = '0;
    repeat (10) cycle();
    chk("reenable8_pattern", cap0[9:0], 10'b1111000011);

    // Reset mid-period with a pending 7: discarded
    load[0] = 1'b1; div_in[7:0] = 8'd7;
    cycle();
    load = '0;
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("midrst_clk_out", clk_out, 0);
    chk("midrst_tick", tick, 0);
    chk("midrst_div_cur", div_cur, {8'd4, 8'd4});
    rst_n = 1'b1; cap0 = '0;
    repeat (8) cycle();
    chk("post_rst_pattern", cap0[7:0], 8'b11001100);
    chk("post_rst_div_cur0", div_cur[7:0], 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
